// File: rtl/mem_test_pkg.sv
// Shared types and the expected-data rule for the memory self-test engine.
package mem_test_pkg;

    // Width used internally by exp_data; callers cast the result down to their word width.
    localparam int unsigned EXP_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RV,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_INCR  = 2'b01,
        MODE_WALK1 = 2'b10,
        MODE_ADDR  = 2'b11
    } mode_e;

    // Expected word for index idx at byte address addr; dw is the real word width.
    function automatic logic [EXP_W-1:0] exp_data(
        input mode_e             mode,
        input logic [EXP_W-1:0]  pattern,
        input logic [31:0]       idx,
        input logic [EXP_W-1:0]  addr,
        input int unsigned       dw
    );
        logic [EXP_W-1:0] r;
        r = pattern;
        case (mode)
            MODE_FIXED: r = pattern;
            MODE_INCR:  r = pattern + EXP_W'(idx);
            MODE_WALK1: r = EXP_W'(1) << (idx % dw);
            MODE_ADDR:  r = addr;
            default:    r = pattern;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_test_pattern_gen.sv
// Combinational expected-data generator for the memory self-test engine.
module mem_test_pattern_gen
    import mem_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] pattern_i,
    input  logic [CNT_WIDTH-1:0]  idx_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] exp_o
);

    // Widen operands, apply the pattern rule, truncate back to the word width.
    always_comb begin
        exp_o = DATA_WIDTH'(exp_data(mode_e'(mode_i), EXP_W'(pattern_i), 32'(idx_i),
                                     EXP_W'(addr_i), DATA_WIDTH));
    end

endmodule

// File: rtl/mem_test_engine.sv
// Memory self-test engine: burst write, read-back and compare over one
// req/gnt/rvalid port, with error counting and first-failure capture.
// Optional march pass (inverted data write + read) enabled by MEM_TEST_MARCH_EN.
module mem_test_engine
    import mem_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CNT_WIDTH-1:0]    num_words_i,
    input  logic [1:0]              mode_i,
    input  logic [DATA_WIDTH-1:0]   pattern_i,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
    output logic [DATA_WIDTH-1:0]   first_err_data_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    idx_q, idx_d;
    logic [CNT_WIDTH-1:0]    num_q, num_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   ferr_addr_q, ferr_addr_d;
    logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
    logic [DATA_WIDTH-1:0]   ferr_data_q, ferr_data_d;
    logic [1:0]              mode_q, mode_d;
    logic                    abort_q, abort_d;
`ifdef MEM_TEST_MARCH_EN
    logic                    phase_q, phase_d;
`endif

    logic [DATA_WIDTH-1:0]   exp_raw;
    logic [DATA_WIDTH-1:0]   exp_word;
    logic                    last_word;
    logic                    stop_req;
    logic                    mismatch;

    mem_test_pattern_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pattern_gen (
        .mode_i    (mode_q),
        .pattern_i (pattern_q),
        .idx_i     (idx_q),
        .addr_i    (addr_q),
        .exp_o     (exp_raw)
    );

`ifdef MEM_TEST_MARCH_EN
    // Second pass writes and checks the complement of the first-pass data.
    assign exp_word = phase_q ? ~exp_raw : exp_raw;
`else
    assign exp_word = exp_raw;
`endif

    assign last_word = (idx_q == (num_q - CNT_ONE));
    // An abort seen now or earlier in this run ends the test at the next safe point.
    assign stop_req  = abort_i | abort_q;
    assign mismatch  = (mem_rdata_i != exp_word);

    // Next-state, counters and failure capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        num_d       = num_q;
        err_cnt_d   = err_cnt_q;
        base_d      = base_q;
        addr_d      = addr_q;
        ferr_addr_d = ferr_addr_q;
        pattern_d   = pattern_q;
        ferr_data_d = ferr_data_q;
        mode_d      = mode_q;
        abort_d     = abort_q;
`ifdef MEM_TEST_MARCH_EN
        phase_d     = phase_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    base_d      = base_addr_i;
                    addr_d      = base_addr_i;
                    num_d       = num_words_i;
                    mode_d      = mode_i;
                    pattern_d   = pattern_i;
                    idx_d       = '0;
                    err_cnt_d   = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    abort_d     = 1'b0;
`ifdef MEM_TEST_MARCH_EN
                    phase_d     = 1'b0;
`endif
                    state_d     = (num_words_i == '0) ? ST_DONE : ST_WR;
                end
            end
            ST_WR: begin
                if (abort_i) abort_d = 1'b1;
                // Request stays up with stable address/data until granted.
                if (mem_gnt_i) begin
                    if (stop_req) begin
                        state_d = ST_DONE;
                    end else if (last_word) begin
                        state_d = ST_RD;
                        idx_d   = '0;
                        addr_d  = base_q;
                    end else begin
                        idx_d  = idx_q + CNT_ONE;
                        addr_d = addr_q + ADDR_STEP;
                    end
                end
            end
            ST_RD: begin
                if (abort_i) abort_d = 1'b1;
                // A granted read still owes its rvalid, so it is always collected in RV.
                if (mem_gnt_i) state_d = ST_RV;
            end
            ST_RV: begin
                if (abort_i) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    if (mismatch) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
                        if (err_cnt_q == '0) begin
                            ferr_addr_d = addr_q;
                            ferr_data_d = mem_rdata_i;
                        end
                    end
                    if (stop_req) begin
                        state_d = ST_DONE;
                    end else if (last_word) begin
`ifdef MEM_TEST_MARCH_EN
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            state_d = ST_WR;
                            idx_d   = '0;
                            addr_d  = base_q;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_RD;
                        idx_d   = idx_q + CNT_ONE;
                        addr_d  = addr_q + ADDR_STEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            err_cnt_q   <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            ferr_addr_q <= '0;
            pattern_q   <= '0;
            ferr_data_q <= '0;
            mode_q      <= '0;
            abort_q     <= 1'b0;
`ifdef MEM_TEST_MARCH_EN
            phase_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            err_cnt_q   <= err_cnt_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            ferr_addr_q <= ferr_addr_d;
            pattern_q   <= pattern_d;
            ferr_data_q <= ferr_data_d;
            mode_q      <= mode_d;
            abort_q     <= abort_d;
`ifdef MEM_TEST_MARCH_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign mem_req_o        = (state_q == ST_WR) || (state_q == ST_RD);
    assign mem_we_o         = (state_q == ST_WR);
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = mem_we_o ? exp_word : '0;
    assign mem_be_o         = '1;
    assign busy_o           = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_RV);
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = done_o && (err_cnt_q == '0) && !abort_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = ferr_addr_q;
    assign first_err_data_o = ferr_data_q;

endmodule
